// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer for the single-cycle core's data bus.
// Reads are combinational from Addr and writes commit on the rising edge.
// Irq is driven only from registers.
// Optional prescaler: define MMIO_TIMER_PRESCALE_EN to add the 16-bit PRESC register at 0x10.
// BASE_ADDR must be 32-byte aligned. Its low five bits are not used by the decode.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        Irq
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_VALUE  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    logic             r_en;
    logic             r_auto;
    logic             r_irqen;
    logic             r_tif;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_value;

    logic       w_sel;
    logic [2:0] w_off;
    logic       w_wr_ctrl;
    logic       w_wr_load;
    logic       w_wr_status;
    logic       w_tick;
    logic       w_cnt;
    logic       w_expire;
    logic       w_unused;

    // The window is 32 bytes, so only Addr[31:5] takes part in the decode.
    assign w_sel    = (Addr[31:5] == BASE_ADDR[31:5]);
    assign w_off    = Addr[4:2];
    assign w_unused = ^Addr[1:0];
    assign Sel      = w_sel;

    assign w_wr_ctrl   = MemWrite && w_sel && (w_off == OFF_CTRL);
    assign w_wr_load   = MemWrite && w_sel && (w_off == OFF_LOAD);
    assign w_wr_status = MemWrite && w_sel && (w_off == OFF_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [15:0] r_presc;
    logic [15:0] r_pc;
    logic        w_wr_presc;

    assign w_wr_presc = MemWrite && w_sel && (w_off == OFF_PRESC);
    assign w_tick     = (r_pc == r_presc);

    // Prescale register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_presc <= '0;
        else if (w_wr_presc)
            r_presc <= WriteData[15:0];
    end

    // Prescale counter: it rests at 0 while disabled and restarts on a CTRL or PRESC write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pc <= '0;
        else if (w_wr_ctrl || w_wr_presc || !r_en || (r_pc == r_presc))
            r_pc <= '0;
        else
            r_pc <= r_pc + 16'd1;
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_cnt    = r_en && w_tick;
    assign w_expire = w_cnt && (r_value == '0);

    // Control bits. A software CTRL write takes priority over the hardware clearing EN on a one-shot expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_irqen <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en    <= WriteData[0];
            r_auto  <= WriteData[1];
            r_irqen <= WriteData[2];
        end else if (w_expire && !r_auto) begin
            r_en    <= 1'b0;
        end
    end

    // LOAD register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_load <= '0;
        else if (w_wr_load)
            r_load <= WriteData[CNT_W-1:0];
    end

    // Counter. A LOAD write overrides any decrement or reload on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_value <= '0;
        else if (w_wr_load)
            r_value <= WriteData[CNT_W-1:0];
        else if (w_cnt) begin
            if (r_value != '0)
                r_value <= r_value - CNT_W'(1);
            else if (r_auto)
                r_value <= r_load;
        end
    end

    // Expiry flag. An expiry on the same edge beats a write-1-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tif <= 1'b0;
        else if (w_expire)
            r_tif <= 1'b1;
        else if (w_wr_status && WriteData[0])
            r_tif <= 1'b0;
    end

    assign Irq = r_tif & r_irqen;

    // Combinational read mux. Counters are zero-extended, and anything outside the window reads 0.
    always_comb begin
        logic [31:0] v_load;
        logic [31:0] v_value;
        v_load              = '0;
        v_value             = '0;
        v_load[CNT_W-1:0]   = r_load;
        v_value[CNT_W-1:0]  = r_value;
        ReadData            = '0;
        if (w_sel) begin
            case (w_off)
                OFF_CTRL:   ReadData = {29'd0, r_irqen, r_auto, r_en};
                OFF_LOAD:   ReadData = v_load;
                OFF_VALUE:  ReadData = v_value;
                OFF_STATUS: ReadData = {31'd0, r_tif};
`ifdef MMIO_TIMER_PRESCALE_EN
                OFF_PRESC:  ReadData = {16'd0, r_presc};
`endif
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed testbench for mmio_timer.
// Expected values are hand-computed.
module tb_mmio_timer;

    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] CTRL   = BASE + 32'h00;
    localparam logic [31:0] LOAD   = BASE + 32'h04;
    localparam logic [31:0] VALUE  = BASE + 32'h08;
    localparam logic [31:0] STATUS = BASE + 32'h0C;
    localparam logic [31:0] PRESC  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;
    logic        Irq;

    int n_checks = 0;
    int n_errors = 0;

    mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .MemWrite(MemWrite),
        .WriteData(WriteData), .ReadData(ReadData), .Sel(Sel), .Irq(Irq)
    );

    always #5 clk = ~clk;

    // Bus write: drive at the negedge, commit on the posedge, then release just after it.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a; WriteData = d; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0; Addr = VALUE;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        MemWrite = 1'b0; Addr = a;
        #1;
        d = ReadData;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b0; Addr = VALUE; MemWrite = 1'b0; WriteData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            bus_rd(BASE + 32'(i * 4), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_errors++; $display("FAIL reset_read off=%0h got=%h exp=0", i * 4, rd);
            end
        end
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got=%b exp=0", Irq); end
        // Load 5 and start counting, then assert reset mid-count.
        bus_wr(LOAD, 32'd5);
        bus_wr(CTRL, 32'h5);
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd5) begin n_errors++; $display("FAIL prereset_value got=%0d exp=5", rd); end
        reset = 1'b0;
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL async_reset_value got=%0d exp=0", rd); end
        bus_rd(CTRL, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL async_reset_ctrl got=%h exp=0", rd); end
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL async_reset_irq got=%b exp=0", Irq); end
        @(negedge clk);
        reset = 1'b1;
        step();
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL postreset_value got=%0d exp=0", rd); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic [31:0] exp_v [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
        bus_wr(LOAD, 32'd3);
        bus_wr(CTRL, 32'h5);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            bus_rd(VALUE, rd);
            n_checks++;
            if (rd !== exp_v[i]) begin
                n_errors++; $display("FAIL oneshot_value[%0d] got=%0d exp=%0d", i, rd, exp_v[i]);
            end
        end
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL oneshot_tif_early got=%h exp=0", rd); end
        step();
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL oneshot_tif got=%h exp=1", rd); end
        n_checks++;
        if (Irq !== 1'b1) begin n_errors++; $display("FAIL oneshot_irq got=%b exp=1", Irq); end
        bus_rd(CTRL, rd);
        n_checks++;
        if (rd !== 32'h4) begin n_errors++; $display("FAIL oneshot_en_clear got=%h exp=4", rd); end
        step(); step();
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL oneshot_hold got=%0d exp=0", rd); end
        bus_wr(STATUS, 32'h1);
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL oneshot_w1c_irq got=%b exp=0", Irq); end
    endtask

    task automatic test_autoreload();
        logic [31:0] rd;
        logic [31:0] exp_v [7] = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2};
        bus_wr(LOAD, 32'd2);
        bus_wr(CTRL, 32'h3);
        for (int i = 0; i < 7; i++) begin
            if (i != 0) step();
            bus_rd(VALUE, rd);
            n_checks++;
            if (rd !== exp_v[i]) begin
                n_errors++; $display("FAIL auto_value[%0d] got=%0d exp=%0d", i, rd, exp_v[i]);
            end
            if (i == 3) begin
                bus_rd(STATUS, rd);
                n_checks++;
                if (rd !== 32'd1) begin n_errors++; $display("FAIL auto_tif got=%h exp=1", rd); end
            end
            n_checks++;
            if (Irq !== 1'b0) begin n_errors++; $display("FAIL auto_irq[%0d] got=%b exp=0", i, Irq); end
        end
        // The counter is at 2, so this edge decrements to 1 with no expiry and the clear takes effect.
        bus_wr(STATUS, 32'h1);
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL auto_w1c got=%h exp=0", rd); end
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL auto_w1c_value got=%0d exp=1", rd); end
        bus_wr(CTRL, 32'h0);
    endtask

    task automatic test_collisions();
        logic [31:0] rd;
        bus_wr(LOAD, 32'd1);
        bus_wr(CTRL, 32'h3);
        step();
        // The counter is now 0, so the next edge is an expiry edge that coincides with the clear.
        bus_wr(STATUS, 32'h1);
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL collide_w1c_tif got=%h exp=1", rd); end
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL collide_reload got=%0d exp=1", rd); end
        // This edge would decrement 1 to 0, but the LOAD write wins.
        bus_wr(LOAD, 32'd7);
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd7) begin n_errors++; $display("FAIL collide_load got=%0d exp=7", rd); end
        step();
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd6) begin n_errors++; $display("FAIL collide_after_load got=%0d exp=6", rd); end
        bus_wr(CTRL, 32'h0);           // EN is still 1 on this edge: 6 -> 5
        bus_wr(STATUS, 32'h1);
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        @(negedge clk);
        Addr = BASE + 32'h20; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1;
        #1;
        n_checks++;
        if (Sel !== 1'b0) begin n_errors++; $display("FAIL decode_sel_hi got=%b exp=0", Sel); end
        n_checks++;
        if (ReadData !== 32'd0) begin n_errors++; $display("FAIL decode_rd_hi got=%h exp=0", ReadData); end
        @(posedge clk); #1;
        Addr = BASE - 32'h4;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        bus_rd(CTRL, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL decode_ctrl got=%h exp=0", rd); end
        bus_rd(LOAD, rd);
        n_checks++;
        if (rd !== 32'd7) begin n_errors++; $display("FAIL decode_load got=%0d exp=7", rd); end
        bus_rd(BASE + 32'h09, rd);
        n_checks++;
        if (rd !== 32'd5) begin n_errors++; $display("FAIL decode_value_09 got=%0d exp=5", rd); end
        n_checks++;
        if (Sel !== 1'b1) begin n_errors++; $display("FAIL decode_sel_in got=%b exp=1", Sel); end
        bus_wr(BASE + 32'h14, 32'hFFFF_FFFF);
        bus_rd(BASE + 32'h14, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL decode_reserved got=%h exp=0", rd); end
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
`ifdef MMIO_TIMER_PRESCALE_EN
        bus_wr(PRESC, 32'd3);
        bus_rd(PRESC, rd);
        n_checks++;
        if (rd !== 32'd3) begin n_errors++; $display("FAIL presc_readback got=%0d exp=3", rd); end
        bus_wr(LOAD, 32'd1);
        bus_wr(CTRL, 32'h1);
        repeat (3) step();
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL presc_hold got=%0d exp=1", rd); end
        step();
        bus_rd(VALUE, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL presc_dec got=%0d exp=0", rd); end
        repeat (3) step();
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL presc_tif_early got=%h exp=0", rd); end
        step();
        bus_rd(STATUS, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_errors++; $display("FAIL presc_tif got=%h exp=1", rd); end
`else
        bus_wr(PRESC, 32'd3);
        bus_rd(PRESC, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL presc_absent got=%h exp=0", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_collisions();
        test_decode();
        test_prescale();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
